// File: rtl/uart_pkg.sv
// Shared UART definitions: default line settings, receiver state encoding and
// the bit-period helper used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DEFAULT_CLK_FREQ = 50_000_000;
  localparam int DEFAULT_BAUD     = 9600;
  localparam int CNT_W            = 13;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, recovered byte and status strobes out.
interface uart_rx_if;

  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  // master drives the line and consumes the results; slave is the receiver
  modport master (output rx, input data_out, data_valid, frame_err, busy);
  modport slave  (input rx, output data_out, data_valid, frame_err, busy);

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// selectable reset value so idle-high lines and switches can share it.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= {2{RST_VAL}};
    end else begin
      r_sync <= {r_sync[0], i_d};
    end
  end

  assign o_q = r_sync[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM producing a byte strobe on a good
// stop bit and a single error strobe on a low stop bit or held-low break.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int BAUD     = DEFAULT_BAUD
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.slave  bus
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);

  logic             w_rx_s;
  uart_state_e      r_state,      w_state_next;
  logic [CNT_W-1:0] r_clk_cnt,    w_clk_cnt_next;
  logic [2:0]       r_bit_idx,    w_bit_idx_next;
  logic [7:0]       r_shift,      w_shift_next;
  logic [7:0]       r_data_out,   w_data_out_next;
  logic             r_data_valid, w_data_valid_next;
  logic             r_frame_err,  w_frame_err_next;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.rx),
    .o_q   (w_rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_clk_cnt    <= w_clk_cnt_next;
      r_bit_idx    <= w_bit_idx_next;
      r_shift      <= w_shift_next;
      r_data_out   <= w_data_out_next;
      r_data_valid <= w_data_valid_next;
      r_frame_err  <= w_frame_err_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_clk_cnt_next    = r_clk_cnt + 1'b1;
    w_bit_idx_next    = r_bit_idx;
    w_shift_next      = r_shift;
    w_data_out_next   = r_data_out;
    w_data_valid_next = 1'b0;
    w_frame_err_next  = 1'b0;
    case (r_state)
      IDLE: begin
        w_clk_cnt_next = '0;
        if (!w_rx_s) w_state_next = START;
      end
      START: begin
        // a line that is high again at mid start bit was only a glitch
        if (r_clk_cnt == CNT_HALF_LAST) begin
          w_clk_cnt_next = '0;
          w_bit_idx_next = '0;
          w_state_next   = w_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_clk_cnt == CNT_BIT_LAST) begin
          w_clk_cnt_next          = '0;
          w_shift_next[r_bit_idx] = w_rx_s;
          w_bit_idx_next          = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_next = STOP;
        end
      end
      STOP: begin
        // returning to IDLE at mid stop bit lets a back-to-back start be caught
        if (r_clk_cnt == CNT_BIT_LAST) begin
          w_clk_cnt_next = '0;
          if (w_rx_s) begin
            w_data_out_next   = r_shift;
            w_data_valid_next = 1'b1;
            w_state_next      = IDLE;
          end else begin
            w_frame_err_next  = 1'b1;
            w_state_next      = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        w_clk_cnt_next = '0;
        if (w_rx_s) w_state_next = IDLE;
      end
      default: begin
        w_clk_cnt_next = '0;
        w_state_next   = IDLE;
      end
    endcase
  end

  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.busy       = (r_state != IDLE);

endmodule
